// File: rtl/crc10_pkt_monitor.sv
// crc10_pkt_monitor
// Downstream companion of the CRC10 checker. It counts packets per statistics
// window, snapshots the checker's error count at every window end, pulses
// packet_count_overflow to clear that checker counter, and runs a hysteretic
// link-alarm state machine on consecutive packet verdicts.
//
// Ports:
//   clk_390p625M          in   decoder clock
//   rst                   in   synchronous, active-high reset
//   pkt_tail              in   one-cycle strobe in the frame's DATA_TAIL cycle
//   check_result          in   CRC verdict (1 = good), valid one cycle after pkt_tail
//   error_packet_cnt      in   checker's saturating error count, valid with the verdict
//   stat_clr              in   software statistics clear (level or pulse)
//   packet_count_overflow out  one-cycle pulse clearing the checker error counter
//   total_pkt_cnt         out  packets seen in the current window
//   err_snapshot          out  error count captured at the last window end
//   snapshot_valid        out  a snapshot has been taken since reset
//   link_alarm            out  1 = link in alarm state
//   bad_run               out  consecutive bad verdicts, saturating at 15
module crc10_pkt_monitor #(
    parameter int PKT_CNT_W = 22,
    parameter int ERR_CNT_W = 22,
    parameter int BAD_TH    = 4,
    parameter int GOOD_TH   = 16
) (
    input  logic                 clk_390p625M,
    input  logic                 rst,
    input  logic                 pkt_tail,
    input  logic                 check_result,
    input  logic [ERR_CNT_W-1:0] error_packet_cnt,
    input  logic                 stat_clr,
    output logic                 packet_count_overflow,
    output logic [PKT_CNT_W-1:0] total_pkt_cnt,
    output logic [ERR_CNT_W-1:0] err_snapshot,
    output logic                 snapshot_valid,
    output logic                 link_alarm,
    output logic [3:0]           bad_run
);

    typedef enum logic [0:0] {
        ST_OK    = 1'b0,
        ST_ALARM = 1'b1
    } state_t;

    localparam logic [3:0]           BAD_LAST  = 4'(BAD_TH - 1);
    localparam logic [7:0]           GOOD_LAST = 8'(GOOD_TH - 1);
    localparam logic [PKT_CNT_W-1:0] CNT_MAX   = {PKT_CNT_W{1'b1}};
    localparam logic [PKT_CNT_W-1:0] CNT_ONE   = PKT_CNT_W'(1);
    localparam logic [PKT_CNT_W-1:0] CNT_ZERO  = {PKT_CNT_W{1'b0}};

    state_t                 state_r;
    state_t                 state_s;
    logic                   tail_d_r;
    logic [7:0]             good_run_r;
    logic [7:0]             good_run_s;
    logic [3:0]             bad_run_r;
    logic [3:0]             bad_run_s;
    logic [3:0]             bad_inc_s;
    logic                   alarm_s;
    logic [PKT_CNT_W-1:0]   total_pkt_cnt_r;
    logic [ERR_CNT_W-1:0]   err_snapshot_r;
    logic                   snapshot_valid_r;
    logic                   overflow_r;
    logic                   wrap_s;

    // Verdict and error count arrive one cycle after pkt_tail; align to them.
    always_ff @(posedge clk_390p625M) begin
        if (rst) begin
            tail_d_r <= 1'b0;
        end else begin
            tail_d_r <= pkt_tail;
        end
    end

    // Window wraps when a packet lands while the counter is all-ones.
    assign wrap_s = tail_d_r & (total_pkt_cnt_r == CNT_MAX);

    // Packet counter, window-end snapshot and checker-clear pulse.
    // stat_clr outranks a coincident packet: that packet is simply not counted.
    always_ff @(posedge clk_390p625M) begin
        if (rst) begin
            total_pkt_cnt_r  <= CNT_ZERO;
            err_snapshot_r   <= {ERR_CNT_W{1'b0}};
            snapshot_valid_r <= 1'b0;
            overflow_r       <= 1'b0;
        end else if (stat_clr) begin
            total_pkt_cnt_r  <= CNT_ZERO;
            overflow_r       <= 1'b1;
        end else if (tail_d_r) begin
            total_pkt_cnt_r  <= total_pkt_cnt_r + CNT_ONE;
            if (wrap_s) begin
                err_snapshot_r   <= error_packet_cnt;
                snapshot_valid_r <= 1'b1;
                overflow_r       <= 1'b1;
            end else begin
                overflow_r       <= 1'b0;
            end
        end else begin
            overflow_r       <= 1'b0;
        end
    end

    // Saturating increment of the consecutive-bad counter.
    always_comb begin
        bad_inc_s = (bad_run_r == 4'd15) ? 4'd15 : (bad_run_r + 4'd1);
    end

    // Alarm FSM state and run-counter register.
    always_ff @(posedge clk_390p625M) begin
        if (rst) begin
            state_r    <= ST_ALARM;
            good_run_r <= 8'd0;
            bad_run_r  <= 4'd0;
        end else begin
            state_r    <= state_s;
            good_run_r <= good_run_s;
            bad_run_r  <= bad_run_s;
        end
    end

    // Alarm FSM next state: verdicts are processed even under stat_clr.
    always_comb begin
        state_s    = state_r;
        good_run_s = good_run_r;
        bad_run_s  = bad_run_r;
        if (tail_d_r) begin
            case (state_r)
                ST_OK: begin
                    good_run_s = 8'd0;
                    if (check_result) begin
                        bad_run_s = 4'd0;
                    end else begin
                        bad_run_s = bad_inc_s;
                        if (bad_run_r >= BAD_LAST) begin
                            state_s = ST_ALARM;
                        end else begin
                            state_s = ST_OK;
                        end
                    end
                end
                ST_ALARM: begin
                    if (check_result) begin
                        bad_run_s = 4'd0;
                        if (good_run_r >= GOOD_LAST) begin
                            state_s    = ST_OK;
                            good_run_s = 8'd0;
                        end else begin
                            good_run_s = good_run_r + 8'd1;
                        end
                    end else begin
                        good_run_s = 8'd0;
                        bad_run_s  = bad_inc_s;
                    end
                end
                default: begin
                    state_s    = ST_ALARM;
                    good_run_s = 8'd0;
                    bad_run_s  = 4'd0;
                end
            endcase
        end else begin
            state_s    = state_r;
            good_run_s = good_run_r;
            bad_run_s  = bad_run_r;
        end
    end

    // Alarm FSM output decode (from the state register only).
    always_comb begin
        alarm_s = (state_r == ST_ALARM);
    end

    assign packet_count_overflow = overflow_r;
    assign total_pkt_cnt         = total_pkt_cnt_r;
    assign err_snapshot          = err_snapshot_r;
    assign snapshot_valid        = snapshot_valid_r;
    assign link_alarm            = alarm_s;
    assign bad_run               = bad_run_r;

endmodule

// File: tb/tb_crc10_pkt_monitor.sv
// Testbench for crc10_pkt_monitor. Two instances share all inputs: one with the
// default 22-bit window counter and one with a 4-bit counter (16-packet window)
// so window wrap and snapshot behaviour are reachable in a short run.
`timescale 1ns/1ps
module tb_crc10_pkt_monitor;

    localparam int ERR_W   = 22;
    localparam int WA      = 22;
    localparam int WB      = 4;
    localparam int BAD_TH  = 4;
    localparam int GOOD_TH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             pkt_tail;
    logic             check_result;
    logic [ERR_W-1:0] error_packet_cnt;
    logic             stat_clr;

    logic             ovf_a, valid_a, alarm_a;
    logic [WA-1:0]    cnt_a;
    logic [ERR_W-1:0] snap_a;
    logic [3:0]       bad_a;
    logic             ovf_b, valid_b, alarm_b;
    logic [WB-1:0]    cnt_b;
    logic [ERR_W-1:0] snap_b;
    logic [3:0]       bad_b;

    always #1 clk = ~clk;

    crc10_pkt_monitor #(.PKT_CNT_W(WA), .ERR_CNT_W(ERR_W), .BAD_TH(BAD_TH), .GOOD_TH(GOOD_TH)) dut_a (
        .clk_390p625M(clk), .rst(rst), .pkt_tail(pkt_tail), .check_result(check_result),
        .error_packet_cnt(error_packet_cnt), .stat_clr(stat_clr),
        .packet_count_overflow(ovf_a), .total_pkt_cnt(cnt_a), .err_snapshot(snap_a),
        .snapshot_valid(valid_a), .link_alarm(alarm_a), .bad_run(bad_a));

    crc10_pkt_monitor #(.PKT_CNT_W(WB), .ERR_CNT_W(ERR_W), .BAD_TH(BAD_TH), .GOOD_TH(GOOD_TH)) dut_b (
        .clk_390p625M(clk), .rst(rst), .pkt_tail(pkt_tail), .check_result(check_result),
        .error_packet_cnt(error_packet_cnt), .stat_clr(stat_clr),
        .packet_count_overflow(ovf_b), .total_pkt_cnt(cnt_b), .err_snapshot(snap_b),
        .snapshot_valid(valid_b), .link_alarm(alarm_b), .bad_run(bad_b));

    int errors = 0;
    int checks = 0;

    // Packet-level reference model: consecutive verdict tallies and window counts.
    int               m_bad, m_good;
    bit               m_alarm;
    int unsigned      m_cnt_a, m_cnt_b;
    logic [ERR_W-1:0] m_snap_a, m_snap_b;
    bit               m_valid_a, m_valid_b;

    typedef struct {
        bit               good;
        bit               clr;
        logic [ERR_W-1:0] err;
        logic             exp_alarm;
        logic [3:0]       exp_bad;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_bad = 0; m_good = 0; m_alarm = 1'b1;
        m_cnt_a = 0; m_cnt_b = 0;
        m_snap_a = '0; m_snap_b = '0;
        m_valid_a = 1'b0; m_valid_b = 1'b0;
    endfunction

    function automatic void model_pkt(input bit good, input bit clr, input logic [ERR_W-1:0] err,
                                      output bit ovf_ea, output bit ovf_eb);
        int unsigned win_a, win_b;
        win_a = 32'd1 << WA;
        win_b = 32'd1 << WB;
        if (good) begin
            m_good++;
            m_bad = 0;
            if (m_alarm && m_good >= GOOD_TH) begin
                m_alarm = 1'b0;
                m_good  = 0;
            end
        end else begin
            m_bad++;
            m_good = 0;
            if (!m_alarm && m_bad >= BAD_TH) m_alarm = 1'b1;
        end
        ovf_ea = clr; ovf_eb = clr;
        if (clr) begin
            m_cnt_a = 0; m_cnt_b = 0;
        end else begin
            m_cnt_a = (m_cnt_a + 1) % win_a;
            m_cnt_b = (m_cnt_b + 1) % win_b;
            if (m_cnt_a == 0) begin m_snap_a = err; m_valid_a = 1'b1; ovf_ea = 1'b1; end
            if (m_cnt_b == 0) begin m_snap_b = err; m_valid_b = 1'b1; ovf_eb = 1'b1; end
        end
    endfunction

    task automatic check_all(input bit ovf_ea, input bit ovf_eb, input string tag);
        int exp_bad;
        exp_bad = (m_bad > 15) ? 15 : m_bad;
        check({tag, "_ovf_a"},   32'(ovf_a),   32'(ovf_ea));
        check({tag, "_cnt_a"},   32'(cnt_a),   m_cnt_a);
        check({tag, "_snap_a"},  32'(snap_a),  32'(m_snap_a));
        check({tag, "_valid_a"}, 32'(valid_a), 32'(m_valid_a));
        check({tag, "_alarm_a"}, 32'(alarm_a), 32'(m_alarm));
        check({tag, "_bad_a"},   32'(bad_a),   32'(exp_bad));
        check({tag, "_ovf_b"},   32'(ovf_b),   32'(ovf_eb));
        check({tag, "_cnt_b"},   32'(cnt_b),   m_cnt_b);
        check({tag, "_snap_b"},  32'(snap_b),  32'(m_snap_b));
        check({tag, "_valid_b"}, 32'(valid_b), 32'(m_valid_b));
        check({tag, "_alarm_b"}, 32'(alarm_b), 32'(m_alarm));
        check({tag, "_bad_b"},   32'(bad_b),   32'(exp_bad));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pkt_tail = 1'b0; stat_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all(1'b0, 1'b0, "reset");
    endtask

    // One packet: strobe, verdict one cycle later, then idle to fill the gap.
    task automatic send_pkt(input bit good, input logic [ERR_W-1:0] err, input bit clr, input int gap);
        bit ea, eb;
        @(negedge clk);
        pkt_tail = 1'b1;
        @(negedge clk);
        pkt_tail = 1'b0; check_result = good; error_packet_cnt = err; stat_clr = clr;
        check_all(1'b0, 1'b0, "tail");
        @(negedge clk);
        stat_clr = 1'b0;
        model_pkt(good, clr, err, ea, eb);
        check_all(ea, eb, "proc");
        @(negedge clk);
        check_all(1'b0, 1'b0, "after");
        repeat (gap - 3) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // From OK: 3 bad, 1 good, 4 bad.
        tbl[0] = '{1'b0, 1'b0, 22'd0, 1'b0, 4'd1};
        tbl[1] = '{1'b0, 1'b0, 22'd0, 1'b0, 4'd2};
        tbl[2] = '{1'b0, 1'b0, 22'd0, 1'b0, 4'd3};
        tbl[3] = '{1'b1, 1'b0, 22'd0, 1'b0, 4'd0};
        tbl[4] = '{1'b0, 1'b0, 22'd0, 1'b0, 4'd1};
        tbl[5] = '{1'b0, 1'b0, 22'd0, 1'b0, 4'd2};
        tbl[6] = '{1'b0, 1'b0, 22'd0, 1'b0, 4'd3};
        tbl[7] = '{1'b0, 1'b0, 22'd0, 1'b1, 4'd4};

        rst = 1'b1; pkt_tail = 1'b0; check_result = 1'b0;
        error_packet_cnt = '0; stat_clr = 1'b0;
        model_reset();
        do_reset();

        // 16 good packets clear the alarm; the 4-bit instance wraps on the 16th.
        for (int i = 0; i < 16; i++) begin
            send_pkt(1'b1, (i == 15) ? 22'd5 : 22'(i), 1'b0, 4);
        end
        check("t1_alarm", 32'(alarm_a), 32'd0);
        check("t1_cnt",   32'(cnt_a),   32'd16);
        check("t1_bad",   32'(bad_a),   32'd0);
        check("t3_cnt_b", 32'(cnt_b),   32'd0);
        check("t3_snap_b", 32'(snap_b), 32'd5);
        check("t3_valid_b", 32'(valid_b), 32'd1);

        // Table-driven bad/good run sequence.
        for (int i = 0; i < 8; i++) begin
            send_pkt(tbl[i].good, tbl[i].err, tbl[i].clr, 4);
            check($sformatf("tbl%0d_alarm", i), 32'(alarm_a), 32'(tbl[i].exp_alarm));
            check($sformatf("tbl%0d_bad", i),   32'(bad_a),   32'(tbl[i].exp_bad));
        end

        // 20 more bad verdicts: bad_run saturates, alarm stays.
        for (int i = 0; i < 20; i++) send_pkt(1'b0, 22'd9, 1'b0, 4);
        check("sat_bad", 32'(bad_a), 32'd15);
        check("sat_alarm", 32'(alarm_a), 32'd1);

        // stat_clr coincident with a packet at count 7.
        do_reset();
        for (int i = 0; i < 7; i++) send_pkt(1'b1, 22'd3, 1'b0, 4);
        check("clr_pre_cnt", 32'(cnt_a), 32'd7);
        send_pkt(1'b0, 22'd77, 1'b1, 4);
        check("clr_cnt",  32'(cnt_a),  32'd0);
        check("clr_snap", 32'(snap_a), 32'd0);
        check("clr_bad",  32'(bad_a),  32'd1);

        // Level-held stat_clr: overflow follows one cycle behind.
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        check("lvl_ovf1", 32'(ovf_a), 32'd1);
        @(negedge clk);
        check("lvl_ovf2", 32'(ovf_b), 32'd1);
        stat_clr = 1'b0;
        @(negedge clk);
        check("lvl_ovf3", 32'(ovf_a), 32'd0);
        check("lvl_cnt",  32'(cnt_a), 32'd0);

        // Reset one cycle after pkt_tail: the pending packet is discarded.
        for (int i = 0; i < 3; i++) send_pkt(1'b0, 22'd1, 1'b0, 4);
        @(negedge clk);
        pkt_tail = 1'b1;
        @(negedge clk);
        pkt_tail = 1'b0; rst = 1'b1; check_result = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all(1'b0, 1'b0, "rstmid");
        @(negedge clk);
        check_all(1'b0, 1'b0, "rstmid2");

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit g;
            bit c;
            g = ($urandom_range(0, 9) < (((i / 40) % 2 == 0) ? 9 : 3));
            c = ($urandom_range(0, 15) == 0);
            send_pkt(g, 22'($urandom), c, $urandom_range(4, 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
